mips_dec_stage: RTL and testbench

Registered decode/issue stage for the MIPS pipeline, replacing the purely combinational decoder between fetch and execute. Accepts one instruction per cycle over a valid/ready handshake, decodes it into a registered control bundle, interlocks load-use hazards, and holds issue after a branch or jump until execute resolves it. Sits between the fetch latch and the ALU/memory stage.

---
 rtl/mips_dec_stage.sv | 233 +++++++++++++++++++++++
 tb/tb_mips_dec_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_dec_stage.sv
// Registered MIPS decode/issue stage: valid/ready in and out, load-use interlock,
// and an issue hold after a branch/jump until execute resolves it.
module mips_dec_stage #(
  parameter int PC_W        = 32,
  parameter int ALUOP_W     = 5,
  parameter int DELAY_SLOTS = 1,
  parameter int INTERLOCK   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_inst,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  input  logic               br_resolve,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [4:0]         out_rs,
  output logic [4:0]         out_rt,
  output logic [4:0]         out_rd,
  output logic [4:0]         out_shamt,
  output logic [4:0]         out_wreg,
  output logic               out_regwr,
  output logic               out_extop,
  output logic               out_alusrc,
  output logic               out_memwr,
  output logic               out_memtoreg,
  output logic               out_jump,
  output logic               out_branch,
  output logic               out_shiftctl,
  output logic               out_signctl,
  output logic               out_savepc,
  output logic               out_illegal,
  output logic [ALUOP_W-1:0] out_aluop,
  output logic [15:0]        out_imm16,
  output logic [25:0]        out_jtarget
);

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_NOR  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] ALU_BGTZ = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] ALU_BLEZ = ALUOP_W'(11);
  localparam logic [ALUOP_W-1:0] ALU_BNE  = ALUOP_W'(12);
  localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(13);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [1:0] {RUN, SLOT, WAIT} state_t;

  typedef struct packed {
    logic               regwr;
    logic               extop;
    logic               alusrc;
    logic               memwr;
    logic               memtoreg;
    logic               jump;
    logic               branch;
    logic               shiftctl;
    logic               signctl;
    logic               savepc;
    logic               illegal;
    logic [ALUOP_W-1:0] aluop;
  } ctl_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [4:0]      wreg;
    ctl_t            ctl;
    logic [15:0]     imm16;
    logic [25:0]     jtarget;
  } bundle_t;

  logic [5:0] op;
  logic [5:0] fn;
  ctl_t       ctl;
  logic [4:0] wreg_d;
  logic       is_brj;
  logic       uses_rs;
  logic       uses_rt;
  logic       hazard;
  logic       accept;
  bundle_t    q;
  state_t     state;
  state_t     state_nx;

  assign op = in_inst[31:26];
  assign fn = in_inst[5:0];

  always_comb begin
    // NOTE: every decode output gets a default before the case, so no path can infer a latch.
    ctl    = '0;
    wreg_d = in_inst[20:16];
    case (op)
      OP_RTYPE: begin
        ctl.regwr = 1'b1;
        case (fn)
          6'b100000: ctl.aluop = ALU_ADD;
          6'b100010: ctl.aluop = ALU_SUB;
          6'b100100: ctl.aluop = ALU_AND;
          6'b100101: ctl.aluop = ALU_OR;
          6'b100111: ctl.aluop = ALU_NOR;
          6'b100110: ctl.aluop = ALU_XOR;
          6'b101010: begin ctl.aluop = ALU_SLT; ctl.signctl = 1'b1; end
          6'b101011: ctl.aluop = ALU_SLT;
          6'b000000: ctl.aluop = ALU_SLL;
          6'b000010: ctl.aluop = ALU_SRL;
          6'b000011: ctl.aluop = ALU_SRA;
          6'b000100: begin ctl.aluop = ALU_SLL; ctl.shiftctl = 1'b1; end
          6'b000110: begin ctl.aluop = ALU_SRL; ctl.shiftctl = 1'b1; end
          6'b000111: begin ctl.aluop = ALU_SRA; ctl.shiftctl = 1'b1; end
          default: begin
            ctl         = '0;
            ctl.illegal = 1'b1;
          end
        endcase
        if (!ctl.illegal) wreg_d = in_inst[15:11];
      end
      6'b001000: begin ctl.aluop = ALU_ADD; ctl.regwr = 1'b1; ctl.alusrc = 1'b1; ctl.extop = 1'b1; end
      6'b001100: begin ctl.aluop = ALU_AND; ctl.regwr = 1'b1; ctl.alusrc = 1'b1; end
      6'b001101: begin ctl.aluop = ALU_OR;  ctl.regwr = 1'b1; ctl.alusrc = 1'b1; end
      6'b001110: begin ctl.aluop = ALU_XOR; ctl.regwr = 1'b1; ctl.alusrc = 1'b1; end
      6'b001010: begin
        ctl.aluop = ALU_SLT; ctl.regwr = 1'b1; ctl.alusrc = 1'b1; ctl.extop = 1'b1; ctl.signctl = 1'b1;
      end
      6'b001011: begin ctl.aluop = ALU_SLT; ctl.regwr = 1'b1; ctl.alusrc = 1'b1; ctl.extop = 1'b1; end
      6'b100011: begin
        ctl.aluop = ALU_ADD; ctl.regwr = 1'b1; ctl.extop = 1'b1; ctl.alusrc = 1'b1; ctl.memtoreg = 1'b1;
      end
      OP_SW:     begin ctl.aluop = ALU_ADD; ctl.extop = 1'b1; ctl.alusrc = 1'b1; ctl.memwr = 1'b1; end
      6'b000100: begin ctl.aluop = ALU_SUB;  ctl.branch = 1'b1; end
      6'b000101: begin ctl.aluop = ALU_BNE;  ctl.branch = 1'b1; end
      6'b000110: begin ctl.aluop = ALU_BLEZ; ctl.branch = 1'b1; end
      6'b000111: begin ctl.aluop = ALU_BGTZ; ctl.branch = 1'b1; end
      OP_J:      ctl.jump = 1'b1;
      OP_JAL: begin
        ctl.jump = 1'b1; ctl.savepc = 1'b1; ctl.regwr = 1'b1;
        wreg_d   = 5'd31;
      end
      default:   ctl.illegal = 1'b1;
    endcase
  end

  assign is_brj  = ctl.branch | ctl.jump;
  assign uses_rs = (op != OP_J) && (op != OP_JAL);
  assign uses_rt = (op == OP_RTYPE) || (op == OP_SW) || (op[5:2] == 4'b0001);

  // Only LW sets memtoreg, so it marks a held load for the interlock.
  assign hazard = (INTERLOCK != 0) && out_valid && q.ctl.memtoreg && (q.wreg != 5'd0) &&
                  ((uses_rs && (q.wreg == in_inst[25:21])) ||
                   (uses_rt && (q.wreg == in_inst[20:16])));

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush && (state != WAIT);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nx = state;
    if (flush)
      state_nx = RUN;
    else if (accept && is_brj && (state == RUN || br_resolve))
      state_nx = (DELAY_SLOTS != 0) ? SLOT : WAIT;
    else if (br_resolve)
      state_nx = RUN;
    else if (accept && state == SLOT)
      state_nx = WAIT;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      // NOTE: the bundle is reset as well so the outputs read all-zero out of reset.
      q         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      q.pc      <= in_pc;
      q.rs      <= in_inst[25:21];
      q.rt      <= in_inst[20:16];
      q.rd      <= in_inst[15:11];
      q.shamt   <= in_inst[10:6];
      q.wreg    <= wreg_d;
      q.ctl     <= ctl;
      q.imm16   <= in_inst[15:0];
      q.jtarget <= in_inst[25:0];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_pc       = q.pc;
  assign out_rs       = q.rs;
  assign out_rt       = q.rt;
  assign out_rd       = q.rd;
  assign out_shamt    = q.shamt;
  assign out_wreg     = q.wreg;
  assign out_regwr    = q.ctl.regwr;
  assign out_extop    = q.ctl.extop;
  assign out_alusrc   = q.ctl.alusrc;
  assign out_memwr    = q.ctl.memwr;
  assign out_memtoreg = q.ctl.memtoreg;
  assign out_jump     = q.ctl.jump;
  assign out_branch   = q.ctl.branch;
  assign out_shiftctl = q.ctl.shiftctl;
  assign out_signctl  = q.ctl.signctl;
  assign out_savepc   = q.ctl.savepc;
  assign out_illegal  = q.ctl.illegal;
  assign out_aluop    = q.ctl.aluop;
  assign out_imm16    = q.imm16;
  assign out_jtarget  = q.jtarget;

endmodule

// File: tb/tb_mips_dec_stage.sv
// Bench for mips_dec_stage: two instances (slot+interlock, and neither) on shared
// stimulus, checked cycle by cycle against a table-driven reference model.
module tb_mips_dec_stage;
  localparam int N = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs, rt, rd, shamt, wreg;
    logic        regwr, extop, alusrc, memwr, memtoreg, jump, branch;
    logic        shiftctl, signctl, savepc, illegal;
    logic [4:0]  aluop;
    logic [15:0] imm16;
    logic [25:0] jtarget;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, br_resolve = 1'b0, out_ready = 1'b1;
  logic [31:0] in_inst = '0, in_pc = '0;
  logic [N-1:0] in_ready_v, out_valid_v;
  bundle_t      out_bus [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : gen_dut
    logic [31:0] pc;
    logic [4:0]  rs, rt, rd, shamt, wreg, aluop;
    logic        regwr, extop, alusrc, memwr, memtoreg, jump, branch;
    logic        shiftctl, signctl, savepc, illegal, rdy, vld;
    logic [15:0] imm16;
    logic [25:0] jtarget;

    mips_dec_stage #(
      .PC_W(32), .ALUOP_W(5),
      .DELAY_SLOTS((g == 0) ? 1 : 0),
      .INTERLOCK((g == 0) ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy),
      .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .br_resolve(br_resolve),
      .out_valid(vld), .out_ready(out_ready), .out_pc(pc),
      .out_rs(rs), .out_rt(rt), .out_rd(rd), .out_shamt(shamt), .out_wreg(wreg),
      .out_regwr(regwr), .out_extop(extop), .out_alusrc(alusrc), .out_memwr(memwr),
      .out_memtoreg(memtoreg), .out_jump(jump), .out_branch(branch),
      .out_shiftctl(shiftctl), .out_signctl(signctl), .out_savepc(savepc),
      .out_illegal(illegal), .out_aluop(aluop), .out_imm16(imm16), .out_jtarget(jtarget)
    );

    assign in_ready_v[g]  = rdy;
    assign out_valid_v[g] = vld;
    assign out_bus[g] = {pc, rs, rt, rd, shamt, wreg, regwr, extop, alusrc, memwr, memtoreg,
                         jump, branch, shiftctl, signctl, savepc, illegal, aluop, imm16, jtarget};
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference tables: R-type funct -> ALU code (-1 = illegal), plus sign/shift flags.
  int         r_alu [64];
  bit         r_sgn [64];
  bit         r_shc [64];
  logic [5:0] op_pool [22];
  logic [5:0] fn_pool [16];

  task automatic init_tables();
    for (int i = 0; i < 64; i++) begin r_alu[i] = -1; r_sgn[i] = 0; r_shc[i] = 0; end
    r_alu[32] = 0; r_alu[34] = 1; r_alu[36] = 2; r_alu[37] = 3; r_alu[39] = 4; r_alu[38] = 8;
    r_alu[42] = 6; r_sgn[42] = 1; r_alu[43] = 6;
    r_alu[0] = 13; r_alu[2] = 5; r_alu[3] = 9;
    r_alu[4] = 13; r_alu[6] = 5; r_alu[7] = 9; r_shc[4] = 1; r_shc[6] = 1; r_shc[7] = 1;
    op_pool = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd8, 6'd12, 6'd13, 6'd14, 6'd10, 6'd11,
                6'd35, 6'd35, 6'd43, 6'd4, 6'd5, 6'd6, 6'd7, 6'd2, 6'd3, 6'd63, 6'd16};
    fn_pool = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd38, 6'd42, 6'd43,
                6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd8, 6'd63};
  endtask

  function automatic bundle_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
    bundle_t    b;
    logic [5:0] op;
    int         alu;
    b = '0; op = i[31:26]; alu = -1;
    b.pc = pc; b.rs = i[25:21]; b.rt = i[20:16]; b.rd = i[15:11]; b.shamt = i[10:6];
    b.imm16 = i[15:0]; b.jtarget = i[25:0]; b.wreg = i[20:16];
    if (op == 6'd0) begin
      alu = r_alu[i[5:0]];
      if (alu >= 0) begin
        b.regwr = 1; b.wreg = i[15:11]; b.signctl = r_sgn[i[5:0]]; b.shiftctl = r_shc[i[5:0]];
      end
    end else begin
      case (op)
        6'd8:  begin alu = 0; b.regwr = 1; b.alusrc = 1; b.extop = 1; end
        6'd12: begin alu = 2; b.regwr = 1; b.alusrc = 1; end
        6'd13: begin alu = 3; b.regwr = 1; b.alusrc = 1; end
        6'd14: begin alu = 8; b.regwr = 1; b.alusrc = 1; end
        6'd10: begin alu = 6; b.regwr = 1; b.alusrc = 1; b.extop = 1; b.signctl = 1; end
        6'd11: begin alu = 6; b.regwr = 1; b.alusrc = 1; b.extop = 1; end
        6'd35: begin alu = 0; b.regwr = 1; b.alusrc = 1; b.extop = 1; b.memtoreg = 1; end
        6'd43: begin alu = 0; b.alusrc = 1; b.extop = 1; b.memwr = 1; end
        6'd4:  begin alu = 1;  b.branch = 1; end
        6'd5:  begin alu = 12; b.branch = 1; end
        6'd6:  begin alu = 11; b.branch = 1; end
        6'd7:  begin alu = 10; b.branch = 1; end
        6'd2:  begin alu = 0; b.jump = 1; end
        6'd3:  begin alu = 0; b.jump = 1; b.savepc = 1; b.regwr = 1; b.wreg = 5'd31; end
        default: alu = -1;
      endcase
    end
    if (alu < 0) b.illegal = 1;
    else         b.aluop = 5'(alu);
    return b;
  endfunction

  // Model state per instance: held bundle, valid, held-is-load, FSM (0 run, 1 slot, 2 wait).
  bundle_t mb   [N];
  bit      mv   [N];
  bit      mlw  [N];
  int      mst  [N];
  bit      mrdy [N];

  function automatic bit ref_hazard(input int k, input logic [31:0] i);
    logic [5:0] op;
    bit rs_use, rt_use;
    op = i[31:26];
    if (k != 0) return 0;
    if (!mv[k] || !mlw[k] || mb[k].wreg == 5'd0) return 0;
    rs_use = !(op == 6'd2 || op == 6'd3);
    rt_use = (op == 6'd0) || (op == 6'd43) || (op >= 6'd4 && op <= 6'd7);
    return (rs_use && mb[k].wreg == i[25:21]) || (rt_use && mb[k].wreg == i[20:16]);
  endfunction

  // Called at a negedge with inputs driven: compare, clock once, advance the model.
  task automatic cycle();
    bundle_t nb;
    bit      acc, brj;
    #1;
    for (int k = 0; k < N; k++) begin
      mrdy[k] = (!mv[k] || out_ready) && !ref_hazard(k, in_inst) && !flush && mst[k] != 2;
      check($sformatf("in_ready[%0d]", k), 128'(in_ready_v[k]), 128'(mrdy[k]));
      check($sformatf("out_valid[%0d]", k), 128'(out_valid_v[k]), 128'(mv[k]));
      check($sformatf("bundle[%0d]", k), 128'(out_bus[k]), 128'(mb[k]));
    end
    @(posedge clk);
    nb  = ref_decode(in_inst, in_pc);
    brj = nb.branch || nb.jump;
    for (int k = 0; k < N; k++) begin
      acc = in_valid && mrdy[k];
      if (flush) begin
        mv[k] = 0; mst[k] = 0;
      end else begin
        if (acc && brj && (mst[k] == 0 || br_resolve)) mst[k] = (k == 0) ? 1 : 2;
        else if (br_resolve)                           mst[k] = 0;
        else if (acc && mst[k] == 1)                   mst[k] = 2;
        if (acc) begin
          mb[k] = nb; mlw[k] = (in_inst[31:26] == 6'd35); mv[k] = 1;
        end else if (out_ready) begin
          mv[k] = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    for (int k = 0; k < N; k++) begin
      mv[k] = 0; mlw[k] = 0; mst[k] = 0; mb[k] = '0;
      check($sformatf("rst_valid[%0d]", k), 128'(out_valid_v[k]), 128'(0));
      check($sformatf("rst_bundle[%0d]", k), 128'(out_bus[k]), 128'(0));
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    in_valid = v; in_inst = inst; in_pc = pc;
  endtask

  function automatic logic [31:0] r_inst(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] i_inst(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    w[31:26] = op_pool[$urandom_range(0, 21)];
    w[25:21] = 5'($urandom_range(0, 3));
    w[20:16] = 5'($urandom_range(0, 3));
    w[15:11] = 5'($urandom_range(0, 3));
    if (w[31:26] == 6'd0) w[5:0] = fn_pool[$urandom_range(0, 15)];
    return w;
  endfunction

  int t_add [N];

  initial begin
    init_tables();
    apply_reset();
    #1;
    check("rdy_after_rst0", 128'(in_ready_v[0]), 128'(1));
    check("rdy_after_rst1", 128'(in_ready_v[1]), 128'(1));

    // Back-to-back issue: add, ori, sw, jal.
    drive(1, r_inst(1, 2, 3, 32), 32'h100); cycle();
    drive(1, i_inst(13, 1, 4, 16'h55), 32'h104); cycle();
    check("ori_aluop", 128'(gen_dut[0].aluop), 128'(3));
    check("ori_extop", 128'(gen_dut[0].extop), 128'(0));
    drive(1, i_inst(43, 1, 4, 8), 32'h108); cycle();
    check("sw_memwr", 128'(gen_dut[0].memwr), 128'(1));
    check("sw_regwr", 128'(gen_dut[0].regwr), 128'(0));
    drive(1, {6'd3, 26'h40}, 32'h10c); cycle();
    check("jal_wreg", 128'(gen_dut[0].wreg), 128'(31));
    check("jal_savepc", 128'(gen_dut[0].savepc), 128'(1));
    drive(0, '0, '0); br_resolve = 1'b1; cycle(); br_resolve = 1'b0;

    // Load-use: lw $5 then add $6,$5,$1.
    drive(1, i_inst(35, 1, 5, 0), 32'h200); cycle();
    drive(1, r_inst(5, 1, 6, 32), 32'h204);
    t_add = '{-1, -1};
    for (int t = 1; t <= 2; t++) begin
      cycle();
      if (t == 1) check("lu_bubble", 128'(out_valid_v[0]), 128'(0));
      for (int k = 0; k < N; k++)
        if (t_add[k] < 0 && out_valid_v[k] && out_bus[k].pc == 32'h204) t_add[k] = t;
    end
    check("lu_lat_interlock", 128'(t_add[0]), 128'(2));
    check("lu_lat_no_interlock", 128'(t_add[1]), 128'(1));
    drive(0, '0, '0); cycle();

    // beq: one slot for instance 0, immediate block for instance 1.
    drive(1, i_inst(4, 1, 2, 4), 32'h300); cycle();
    drive(1, r_inst(1, 2, 7, 32), 32'h304); #1;
    check("slot_rdy_ds1", 128'(in_ready_v[0]), 128'(1));
    check("slot_rdy_ds0", 128'(in_ready_v[1]), 128'(0));
    cycle(); #1;
    check("wait_rdy_ds1", 128'(in_ready_v[0]), 128'(0));
    cycle(); #1;
    check("wait_rdy_ds1_hold", 128'(in_ready_v[0]), 128'(0));
    drive(0, '0, '0); br_resolve = 1'b1; cycle(); br_resolve = 1'b0; #1;
    check("resolved_rdy0", 128'(in_ready_v[0]), 128'(1));

    // Illegal opcode still issues.
    drive(1, {6'b111111, 26'h123456}, 32'h400); cycle();
    check("ill_flag", 128'(gen_dut[0].illegal), 128'(1));
    check("ill_regwr", 128'(gen_dut[0].regwr), 128'(0));
    check("ill_memwr", 128'(gen_dut[0].memwr), 128'(0));
    drive(0, '0, '0); cycle();

    // Flush while stalled in WAIT.
    drive(1, i_inst(4, 1, 2, 4), 32'h500); cycle();
    drive(1, r_inst(1, 2, 7, 32), 32'h504); cycle();
    drive(0, '0, '0); out_ready = 1'b0; cycle();
    flush = 1'b1; cycle(); flush = 1'b0; #1;
    check("flush_valid", 128'(out_valid_v[0]), 128'(0));
    check("flush_run_rdy", 128'(in_ready_v[0]), 128'(1));
    out_ready = 1'b1;

    // Reset mid-stream.
    drive(1, r_inst(1, 2, 3, 32), 32'h600); cycle();
    check("pre_rst_valid", 128'(out_valid_v[0]), 128'(1));
    apply_reset();
    drive(0, '0, '0); #1;
    check("rdy_after_midrst", 128'(in_ready_v[0]), 128'(1));
    cycle();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      in_valid   = ($urandom_range(0, 9) < 8);
      in_inst    = rand_inst();
      in_pc      = $urandom;
      out_ready  = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 31) == 0);
      br_resolve = ($urandom_range(0, 9) < 2);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
